// File: rtl/apv_frame_emulator_pkg.sv
// Shared constants and types for the APV25 frame emulator.
package apv_frame_emulator_pkg;

  localparam int DEF_DATA_W      = 12;
  localparam int DEF_MAX_PENDING = 15;
  localparam int PEND_W          = 4;
  localparam int N_HEADER_ONES   = 3;
  localparam int ADDR_BITS       = 8;
  localparam int N_CHANNELS      = 128;
  localparam int FRAME_LEN       = N_HEADER_ONES + ADDR_BITS + 1 + N_CHANNELS;
  localparam int MIN_SYNC_PERIOD = 3;

  // Sample index within a frame at which each section begins.
  localparam int IDX_ADDR = N_HEADER_ONES;
  localparam int IDX_ERR  = IDX_ADDR + ADDR_BITS;
  localparam int IDX_ANA  = IDX_ERR + 1;
  localparam int IDX_LAST = FRAME_LEN - 1;

  typedef enum logic [1:0] {
    PAT_CONST     = 2'd0,
    PAT_RAMP      = 2'd1,
    PAT_TABLE     = 2'd2,
    PAT_CONST_ALT = 2'd3
  } pattern_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_ERR,
    ST_ANA
  } frame_state_e;

  // Tick spacing below 4 clocks is not meaningful, so the period is floored.
  function automatic logic [7:0] clamp_period(input logic [7:0] period);
    return (period < 8'(MIN_SYNC_PERIOD)) ? 8'(MIN_SYNC_PERIOD) : period;
  endfunction

endpackage

// File: rtl/apv_frame_emulator_if.sv
// Sample-stream and pattern-table bus between the emulator and its consumer.
interface apv_frame_emulator_if #(
  parameter int DATA_W = 12
);
  logic [6:0]        PATTERN_ADDRESS;
  logic [DATA_W-1:0] PATTERN_DATA;
  logic [DATA_W-1:0] APV_DATA;
  logic              FRAME_ACTIVE;
  logic              FRAME_DONE;

  modport master (
    output PATTERN_ADDRESS,
    output APV_DATA,
    output FRAME_ACTIVE,
    output FRAME_DONE,
    input  PATTERN_DATA
  );

  modport slave (
    input  PATTERN_ADDRESS,
    input  APV_DATA,
    input  FRAME_ACTIVE,
    input  FRAME_DONE,
    output PATTERN_DATA
  );
endinterface

// File: rtl/apv_tick_generator.sv
// Free-running sync phase counter; produces the slot strobe at phase 0.
module apv_tick_generator
  import apv_frame_emulator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] sync_period,
  output logic       slot
);

  logic [7:0] phase_reg;
  logic [7:0] period_max;

  assign period_max = clamp_period(sync_period);
  assign slot       = enable && (phase_reg == 8'd0);

  // Count 0..period_max while enabled; park at 0 when disabled so the first enabled clock is a slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= 8'd0;
    end else if (!enable) begin
      phase_reg <= 8'd0;
    end else if (phase_reg >= period_max) begin
      phase_reg <= 8'd0;
    end else begin
      phase_reg <= phase_reg + 8'd1;
    end
  end

endmodule

// File: rtl/apv_frame_emulator.sv
// APV25 output-stream emulator: sync ticks when idle, 140-sample frames on trigger.
module apv_frame_emulator
  import apv_frame_emulator_pkg::*;
#(
  parameter int MAX_PENDING = DEF_MAX_PENDING,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                CLK,
  input  logic                RSTb,
  input  logic                ENABLE,
  input  logic                CLEAR,
  input  logic                TRIGGER,
  input  logic [7:0]          SYNC_PERIOD,
  input  logic [DATA_W-1:0]   HIGH_LEVEL,
  input  logic [DATA_W-1:0]   LOW_LEVEL,
  input  logic                ERR_FLAG,
  input  logic [1:0]          PATTERN_MODE,
  input  logic [DATA_W-1:0]   BASELINE,
  input  logic [7:0]          RAMP_STEP,
  output logic [PEND_W-1:0]   PENDING,
  output logic                OVERFLOW,
  apv_frame_emulator_if.master bus
);

  frame_state_e      state_reg, state_next;
  logic [7:0]        idx_reg, idx_next;      // sample index within the frame, 0..139
  logic [7:0]        addr_reg;               // pipeline address emitted in the next frame
  logic [PEND_W-1:0] pending_reg;
  logic              overflow_reg;
  logic [DATA_W-1:0] apv_data_reg, sample_next;
  logic              frame_active_reg, frame_active_next;
  logic              frame_done_reg, frame_done_next;
  logic [6:0]        pattern_address_reg, pattern_address_next;
  logic              slot, frame_start, frame_end, trig_accept, addr_bit;
  logic [6:0]        channel;
  logic [18:0]       ramp_sum;
  logic [DATA_W-1:0] ramp_sat, analog_sample;

  apv_tick_generator u_tick (
    .clk         (CLK),
    .rst_n       (RSTb),
    .enable      (ENABLE),
    .sync_period (SYNC_PERIOD),
    .slot        (slot)
  );

  // A frame starts only in IDLE at a slot; a CLEAR in that cycle cancels the queued work instead.
  assign frame_start = (state_reg == ST_IDLE) && slot && (pending_reg != '0) && !CLEAR;
  assign trig_accept = TRIGGER && ENABLE;

  assign channel  = 7'(idx_reg - 8'(IDX_ANA));
  assign addr_bit = addr_reg[3'(IDX_ERR - 1 - int'(idx_reg))];
  assign ramp_sum = 19'(BASELINE) + 19'(channel) * 19'(RAMP_STEP);
  assign ramp_sat = (ramp_sum > 19'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : ramp_sum[DATA_W-1:0];

  // Analog value for the current channel; table data arrives for the address driven last clock.
  always_comb begin
    analog_sample = BASELINE;
    case (pattern_mode_e'(PATTERN_MODE))
      PAT_RAMP:  analog_sample = ramp_sat;
      PAT_TABLE: analog_sample = bus.PATTERN_DATA;
      default:   analog_sample = BASELINE;
    endcase
  end

  // Frame sequencer; the IDLE slot cycle itself carries header one, so HDR covers only two clocks.
  always_comb begin
    state_next           = state_reg;
    idx_next             = idx_reg;
    sample_next          = LOW_LEVEL;
    frame_active_next    = 1'b0;
    frame_done_next      = 1'b0;
    frame_end            = 1'b0;
    pattern_address_next = pattern_address_reg;
    case (state_reg)
      ST_IDLE: begin
        if (slot) begin
          sample_next = HIGH_LEVEL;
          if (frame_start) begin
            frame_active_next = 1'b1;
            state_next        = ST_HDR;
            idx_next          = 8'd1;
          end
        end
      end
      ST_HDR: begin
        sample_next       = HIGH_LEVEL;
        frame_active_next = 1'b1;
        idx_next          = idx_reg + 8'd1;
        if (idx_reg == 8'(IDX_ADDR - 1)) state_next = ST_ADDR;
      end
      ST_ADDR: begin
        sample_next       = addr_bit ? HIGH_LEVEL : LOW_LEVEL;
        frame_active_next = 1'b1;
        idx_next          = idx_reg + 8'd1;
        if (idx_reg == 8'(IDX_ERR - 1)) state_next = ST_ERR;
      end
      ST_ERR: begin
        sample_next       = ERR_FLAG ? HIGH_LEVEL : LOW_LEVEL;
        frame_active_next = 1'b1;
        idx_next          = idx_reg + 8'd1;
        state_next        = ST_ANA;
      end
      ST_ANA: begin
        sample_next       = analog_sample;
        frame_active_next = 1'b1;
        idx_next          = idx_reg + 8'd1;
        if (idx_reg == 8'(IDX_LAST)) begin
          frame_done_next = 1'b1;
          frame_end       = 1'b1;
          state_next      = ST_IDLE;
          idx_next        = 8'd0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = 8'd0;
      end
    endcase
    // Present the channel index one clock ahead of the sample it selects.
    if (state_next == ST_ANA) pattern_address_next = 7'(idx_next - 8'(IDX_ANA));
  end

  // FSM state and sample-index registers.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Registered stream outputs, all aligned to the same sample.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      apv_data_reg        <= '0;
      frame_active_reg    <= 1'b0;
      frame_done_reg      <= 1'b0;
      pattern_address_reg <= 7'd0;
    end else begin
      apv_data_reg        <= sample_next;
      frame_active_reg    <= frame_active_next;
      frame_done_reg      <= frame_done_next;
      pattern_address_reg <= pattern_address_next;
    end
  end

  // Pipeline address advances once per completed frame; CLEAR restarts it at 0.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      addr_reg <= 8'd0;
    end else if (CLEAR) begin
      addr_reg <= 8'd0;
    end else if (frame_end) begin
      addr_reg <= addr_reg + 8'd1;
    end
  end

  // Trigger queue: saturating count with sticky overflow; a trigger at frame start nets to no change.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else if (CLEAR) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      case ({trig_accept, frame_start})
        2'b10: begin
          if (pending_reg == PEND_W'(MAX_PENDING)) overflow_reg <= 1'b1;
          else pending_reg <= pending_reg + 1'b1;
        end
        2'b01:   pending_reg <= pending_reg - 1'b1;
        default: pending_reg <= pending_reg;
      endcase
    end
  end

  assign bus.APV_DATA        = apv_data_reg;
  assign bus.FRAME_ACTIVE    = frame_active_reg;
  assign bus.FRAME_DONE      = frame_done_reg;
  assign bus.PATTERN_ADDRESS = pattern_address_reg;
  assign PENDING             = pending_reg;
  assign OVERFLOW            = overflow_reg;

endmodule

// File: tb/tb_apv_frame_emulator.sv
// Directed self-checking bench for apv_frame_emulator.
module tb_apv_frame_emulator;

  logic        clk = 1'b0;
  logic        rstb, enable, clear, trigger, err_flag, overflow;
  logic [7:0]  sync_period, ramp_step;
  logic [11:0] high_level, low_level, baseline;
  logic [1:0]  pattern_mode;
  logic [3:0]  pending;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] cap_data[140];
  logic        cap_done[140];
  logic        cap_act[140];
  logic [6:0]  cap_pa[140];

  always #5 clk = ~clk;

  apv_frame_emulator_if bus ();
  // External pattern table: table[c] = c*32, combinational lookup.
  assign bus.PATTERN_DATA = {bus.PATTERN_ADDRESS, 5'd0};

  apv_frame_emulator dut (
    .CLK(clk), .RSTb(rstb), .ENABLE(enable), .CLEAR(clear), .TRIGGER(trigger),
    .SYNC_PERIOD(sync_period), .HIGH_LEVEL(high_level), .LOW_LEVEL(low_level),
    .ERR_FLAG(err_flag), .PATTERN_MODE(pattern_mode), .BASELINE(baseline),
    .RAMP_STEP(ramp_step), .PENDING(pending), .OVERFLOW(overflow), .bus(bus)
  );

  function automatic logic [11:0] exp_header(int k, logic [7:0] a, logic e);
    if (k < 3) return high_level;
    if (k < 11) return a[10-k] ? high_level : low_level;
    return e ? high_level : low_level;
  endfunction

  function automatic logic [7:0] decode_addr();
    logic [7:0] a = 8'd0;
    for (int k = 0; k < 8; k++) a = {a[6:0], (cap_data[3+k] == high_level)};
    return a;
  endfunction

  task automatic wait_frame_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.FRAME_ACTIVE === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.APV_DATA === high_level && bus.FRAME_ACTIVE === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // Records the current sample as index 0, then the following 139.
  task automatic capture_frame();
    for (int k = 0; k < 140; k++) begin
      if (k > 0) @(negedge clk);
      cap_data[k] = bus.APV_DATA;
      cap_done[k] = bus.FRAME_DONE;
      cap_act[k]  = bus.FRAME_ACTIVE;
      cap_pa[k]   = bus.PATTERN_ADDRESS;
    end
  endtask

  task automatic trigger_one_frame(input string name);
    bit ok;
    wait_tick(ok);
    trigger = 1'b1; @(negedge clk); trigger = 1'b0;
    wait_frame_start(ok);
    n_checks++;
    if (!ok) $display("FAIL %s_start_timeout: frame_active=%0b required 1", name, bus.FRAME_ACTIVE);
    else n_pass++;
    $display("%s: frame started", name);
  endtask

  task automatic test_reset();
    rstb = 1'b1; enable = 1'b0; clear = 1'b0; trigger = 1'b0; err_flag = 1'b1;
    sync_period = 8'd34; high_level = 12'd3500; low_level = 12'd500;
    baseline = 12'd1000; ramp_step = 8'd3; pattern_mode = 2'd0;
    #2 rstb = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.APV_DATA !== 12'd0) $display("FAIL rst_apv_data: got %0d want 0", bus.APV_DATA); else n_pass++;
    n_checks++; if (bus.FRAME_ACTIVE !== 1'b0) $display("FAIL rst_frame_active: got %0b want 0", bus.FRAME_ACTIVE); else n_pass++;
    n_checks++; if (bus.FRAME_DONE !== 1'b0) $display("FAIL rst_frame_done: got %0b want 0", bus.FRAME_DONE); else n_pass++;
    n_checks++; if (pending !== 4'd0) $display("FAIL rst_pending: got %0d want 0", pending); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (bus.PATTERN_ADDRESS !== 7'd0) $display("FAIL rst_pattern_address: got %0d want 0", bus.PATTERN_ADDRESS); else n_pass++;
    rstb = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.APV_DATA !== low_level) $display("FAIL post_rst_low: got %0d want %0d", bus.APV_DATA, low_level); else n_pass++;
    $display("test_reset: done");
  endtask

  task automatic test_sync_spacing(input logic [7:0] period, input int gap);
    int last = -1, nticks = 0, nbad = 0, first = -1;
    enable = 1'b0; sync_period = period; @(negedge clk); enable = 1'b1;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (bus.APV_DATA === high_level) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last != gap) $display("FAIL sync_gap_p%0d: got %0d want %0d", period, i - last, gap);
          else n_pass++;
        end else first = i;
        last = i; nticks++;
      end else if (bus.APV_DATA !== low_level) nbad++;
    end
    n_checks++; if (first != 0) $display("FAIL sync_first_tick_p%0d: got %0d want 0", period, first); else n_pass++;
    n_checks++; if (nticks != 249 / gap + 1) $display("FAIL sync_count_p%0d: got %0d want %0d", period, nticks, 249 / gap + 1); else n_pass++;
    n_checks++; if (nbad != 0) $display("FAIL sync_idle_level_p%0d: got %0d bad samples want 0", period, nbad); else n_pass++;
    $display("test_sync_spacing: period=%0d ticks=%0d", period, nticks);
  endtask

  task automatic test_enable_off();
    int nbad = 0;
    enable = 1'b0; sync_period = 8'd34;
    trigger = 1'b1; repeat (2) @(negedge clk); trigger = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.APV_DATA !== low_level || bus.FRAME_ACTIVE !== 1'b0) nbad++;
    end
    n_checks++; if (pending !== 4'd0) $display("FAIL disabled_trigger: pending got %0d want 0", pending); else n_pass++;
    n_checks++; if (nbad != 0) $display("FAIL disabled_quiet: got %0d non-idle samples want 0", nbad); else n_pass++;
    enable = 1'b1;
    $display("test_enable_off: done");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int nbad;
    wait_tick(ok);
    trigger = 1'b1; repeat (3) @(negedge clk); trigger = 1'b0;
    n_checks++; if (pending !== 4'd3) $display("FAIL b2b_pending_queued: got %0d want 3", pending); else n_pass++;
    wait_frame_start(ok);
    n_checks++; if (!ok) $display("FAIL b2b_start_timeout: frame_active=%0b required 1", bus.FRAME_ACTIVE); else n_pass++;
    for (int f = 0; f < 3; f++) begin
      if (f > 0) @(negedge clk);
      n_checks++; if (pending !== 4'(2 - f)) $display("FAIL b2b_pending_f%0d: got %0d want %0d", f, pending, 2 - f); else n_pass++;
      capture_frame();
      nbad = 0;
      for (int k = 0; k < 140; k++) begin
        if (cap_act[k] !== 1'b1 || cap_done[k] !== (k == 139)) nbad++;
        if (k < 12 && cap_data[k] !== exp_header(k, 8'(f), err_flag)) nbad++;
      end
      n_checks++; if (nbad != 0) $display("FAIL b2b_frame_f%0d: got %0d bad samples want 0", f, nbad); else n_pass++;
      n_checks++; if (decode_addr() !== 8'(f)) $display("FAIL b2b_addr_f%0d: got %0d want %0d", f, decode_addr(), f); else n_pass++;
      $display("test_back_to_back: frame %0d addr=%0d", f, decode_addr());
    end
    @(negedge clk);
    n_checks++; if (bus.FRAME_ACTIVE !== 1'b0) $display("FAIL b2b_end_active: got %0b want 0", bus.FRAME_ACTIVE); else n_pass++;
    n_checks++; if (bus.APV_DATA !== high_level) $display("FAIL b2b_tick_after: got %0d want %0d", bus.APV_DATA, high_level); else n_pass++;
    n_checks++; if (pending !== 4'd0) $display("FAIL b2b_pending_end: got %0d want 0", pending); else n_pass++;
  endtask

  // Runs 162 further frames so the address counter reaches 0xA5.
  task automatic test_advance_address();
    int issued = 0, done = 0, cycles = 0;
    while (done < 162 && cycles < 30000) begin
      @(negedge clk); cycles++;
      if (bus.FRAME_DONE === 1'b1) done++;
      if (issued < 162 && pending < 4'd14) begin trigger = 1'b1; issued++; end
      else trigger = 1'b0;
    end
    trigger = 1'b0;
    n_checks++; if (done != 162) $display("FAIL advance_frames: got %0d want 162", done); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL advance_overflow: got %0b want 0", overflow); else n_pass++;
    @(negedge clk);
    n_checks++; if (pending !== 4'd0) $display("FAIL advance_pending: got %0d want 0", pending); else n_pass++;
    $display("test_advance_address: %0d frames in %0d cycles", done, cycles);
  endtask

  task automatic test_single_frame();
    int nbad = 0;
    logic [11:0] exp;
    err_flag = 1'b1; pattern_mode = 2'd1; baseline = 12'd1000; ramp_step = 8'd3;
    trigger_one_frame("single");
    capture_frame();
    for (int k = 0; k < 140; k++) begin
      exp = (k < 12) ? exp_header(k, 8'hA5, 1'b1) : 12'(1000 + 3 * (k - 12));
      n_checks++;
      if (cap_data[k] !== exp) $display("FAIL single_sample_%0d: got %0d want %0d", k, cap_data[k], exp);
      else n_pass++;
      if (cap_done[k] !== (k == 139)) nbad++;
    end
    n_checks++; if (nbad != 0) $display("FAIL single_frame_done: got %0d misplaced pulses want 0", nbad); else n_pass++;
    n_checks++; if (cap_data[139] !== 12'd1381) $display("FAIL single_last: got %0d want 1381", cap_data[139]); else n_pass++;
    $display("test_single_frame: addr=%h last=%0d", decode_addr(), cap_data[139]);
  endtask

  task automatic test_mode2();
    int nbad = 0, npa = 0;
    err_flag = 1'b0; pattern_mode = 2'd2;
    trigger_one_frame("mode2");
    capture_frame();
    for (int k = 0; k < 12; k++) if (cap_data[k] !== exp_header(k, 8'hA6, 1'b0)) nbad++;
    for (int k = 12; k < 140; k++) begin
      if (cap_data[k] !== 12'((k - 12) * 32)) nbad++;
      if (cap_pa[k-1] !== 7'(k - 12)) npa++;
    end
    n_checks++; if (nbad != 0) $display("FAIL mode2_samples: got %0d bad samples want 0", nbad); else n_pass++;
    n_checks++; if (npa != 0) $display("FAIL mode2_address_lead: got %0d bad addresses want 0", npa); else n_pass++;
    n_checks++; if (decode_addr() !== 8'hA6) $display("FAIL mode2_frame_addr: got %h want a6", decode_addr()); else n_pass++;
    n_checks++; if (cap_data[139] !== 12'd4064) $display("FAIL mode2_last: got %0d want 4064", cap_data[139]); else n_pass++;
    $display("test_mode2: addr=%h last=%0d", decode_addr(), cap_data[139]);
  endtask

  task automatic test_saturation();
    int nbad = 0;
    err_flag = 1'b1; pattern_mode = 2'd1; baseline = 12'd4000; ramp_step = 8'd255;
    trigger_one_frame("sat");
    capture_frame();
    for (int k = 13; k < 140; k++) if (cap_data[k] !== 12'd4095) nbad++;
    n_checks++; if (cap_data[12] !== 12'd4000) $display("FAIL sat_ch0: got %0d want 4000", cap_data[12]); else n_pass++;
    n_checks++; if (nbad != 0) $display("FAIL sat_ch1_up: got %0d unsaturated want 0", nbad); else n_pass++;
    n_checks++; if (decode_addr() !== 8'hA7) $display("FAIL sat_frame_addr: got %h want a7", decode_addr()); else n_pass++;
    $display("test_saturation: ch0=%0d ch1=%0d", cap_data[12], cap_data[13]);
  endtask

  task automatic test_overflow();
    bit seen_done = 1'b0;
    trigger_one_frame("ovf");
    trigger = 1'b1; repeat (15) @(negedge clk);
    n_checks++; if (pending !== 4'd15) $display("FAIL ovf_pending_full: got %0d want 15", pending); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_not_yet: got %0b want 0", overflow); else n_pass++;
    repeat (2) @(negedge clk); trigger = 1'b0;
    n_checks++; if (pending !== 4'd15) $display("FAIL ovf_pending_sat: got %0d want 15", pending); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", overflow); else n_pass++;
    clear = 1'b1; trigger = 1'b1; @(negedge clk); clear = 1'b0; trigger = 1'b0;
    n_checks++; if (pending !== 4'd0) $display("FAIL clear_pending: got %0d want 0", pending); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL clear_overflow: got %0b want 0", overflow); else n_pass++;
    n_checks++; if (bus.FRAME_ACTIVE !== 1'b1) $display("FAIL clear_keeps_frame: got %0b want 1", bus.FRAME_ACTIVE); else n_pass++;
    for (int i = 0; i < 200 && bus.FRAME_ACTIVE === 1'b1; i++) begin
      @(negedge clk);
      if (bus.FRAME_DONE === 1'b1) seen_done = 1'b1;
    end
    n_checks++; if (seen_done !== 1'b1) $display("FAIL clear_frame_completes: done=%0b want 1", seen_done); else n_pass++;
    $display("test_overflow: done");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    trigger_one_frame("midrst");
    for (int k = 0; k < 72; k++) begin
      if (k > 0) @(negedge clk);
      cap_data[k] = bus.APV_DATA;
    end
    // Address 1: cleared mid-frame, then the completing frame advanced it.
    n_checks++; if (decode_addr() !== 8'd1) $display("FAIL midrst_frame_addr: got %0d want 1", decode_addr()); else n_pass++;
    rstb = 1'b0; #1;
    n_checks++; if (bus.APV_DATA !== 12'd0) $display("FAIL midrst_apv_data: got %0d want 0", bus.APV_DATA); else n_pass++;
    n_checks++; if (bus.FRAME_ACTIVE !== 1'b0) $display("FAIL midrst_frame_active: got %0b want 0", bus.FRAME_ACTIVE); else n_pass++;
    @(negedge clk); rstb = 1'b1;
    wait_tick(ok);
    n_checks++; if (!ok) $display("FAIL midrst_tick_resume: tick seen=%0b want 1", ok); else n_pass++;
    trigger_one_frame("postrst");
    capture_frame();
    n_checks++; if (decode_addr() !== 8'd0) $display("FAIL postrst_addr: got %0d want 0", decode_addr()); else n_pass++;
    $display("test_reset_midframe: post-reset addr=%0d", decode_addr());
  endtask

  initial begin
    test_reset();
    test_sync_spacing(8'd34, 35);
    test_sync_spacing(8'd1, 4);
    test_enable_off();
    test_sync_spacing(8'd34, 35);
    test_back_to_back();
    test_advance_address();
    test_single_frame();
    test_mode2();
    test_saturation();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
